// File: rtl/vga_timing.sv
// Raster timing generator and pixel output stage for the rectangle GPU.
// Optional build macro VGA_TIMING_TEST_PATTERN_EN adds a test_mode input that swaps color_in for colour bars.
module vga_timing #(
  parameter int COORD_WIDTH  = 16,
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int PIPE_LATENCY = 6
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic                   test_mode,
`endif
  input  logic [15:0]            color_in,
  output logic [COORD_WIDTH-1:0] x_coord,
  output logic [COORD_WIDTH-1:0] y_coord,
  output logic                   idle,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [4:0]             red,
  output logic [5:0]             green,
  output logic [4:0]             blue
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int TAIL    = PIPE_LATENCY - 1;

  localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_VIS    = COORD_WIDTH'(H_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] V_VIS    = COORD_WIDTH'(V_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] HS_START = COORD_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_WIDTH-1:0] HS_END   = COORD_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] VS_START = COORD_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_WIDTH-1:0] VS_END   = COORD_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COORD_WIDTH-1:0] ONE      = COORD_WIDTH'(1);

  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic                   idle_q, idle_d;

  logic                    de_raw, hs_raw, vs_raw;
  logic [PIPE_LATENCY-1:0] de_dly_q, de_dly_d;
  logic [PIPE_LATENCY-1:0] hs_dly_q, hs_dly_d;
  logic [PIPE_LATENCY-1:0] vs_dly_q, vs_dly_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [15:0] rgb_q, rgb_d;
  logic [15:0] pix;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam logic [COORD_WIDTH-1:0] BAR_W    = COORD_WIDTH'(H_VISIBLE / 8);
  localparam logic [COORD_WIDTH-1:0] BAR_LAST = COORD_WIDTH'(7);

  logic [COORD_WIDTH-1:0]        bar_full;
  logic [2:0]                    bar_raw;
  logic [PIPE_LATENCY-1:0][2:0]  bar_dly_q, bar_dly_d;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction
`endif

  // Stage 0: raster counters; idle follows the next y so it moves on the same edge as y_coord.
  always_comb begin
    x_d = x_q + ONE;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + ONE;
    end
    idle_d = (y_d >= V_VIS);
  end

  always_comb begin
    de_raw = (x_q < H_VIS) && (y_q < V_VIS);
    hs_raw = !((x_q >= HS_START) && (x_q < HS_END));
    vs_raw = !((y_q >= VS_START) && (y_q < VS_END));
  end

  // Stages 1..PIPE_LATENCY: timing delay line matching the GPU colour latency.
  always_comb begin
    de_dly_d = {de_dly_q[PIPE_LATENCY-2:0], de_raw};
    hs_dly_d = {hs_dly_q[PIPE_LATENCY-2:0], hs_raw};
    vs_dly_d = {vs_dly_q[PIPE_LATENCY-2:0], vs_raw};
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  always_comb begin
    bar_full  = x_q / BAR_W;
    bar_raw   = (bar_full > BAR_LAST) ? 3'd7 : bar_full[2:0];
    bar_dly_d = {bar_dly_q[PIPE_LATENCY-2:0], bar_raw};
  end

  // Bar index is pure data; it only reaches the pins qualified by the delayed de.
  always_ff @(posedge pixel_clk) begin
    bar_dly_q <= bar_dly_d;
  end
`endif

  // Output stage: delay-line tail meets color_in for the same coordinate.
  always_comb begin
    pix = color_in;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (test_mode) pix = bar_color(bar_dly_q[TAIL]);
`endif
    hsync_d = hs_dly_q[TAIL];
    vsync_d = vs_dly_q[TAIL];
    de_d    = de_dly_q[TAIL];
    rgb_d   = de_dly_q[TAIL] ? pix : 16'h0000;
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      idle_q   <= 1'b0;
      de_dly_q <= '0;
      hs_dly_q <= '1;
      vs_dly_q <= '1;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      idle_q   <= idle_d;
      de_dly_q <= de_dly_d;
      hs_dly_q <= hs_dly_d;
      vs_dly_q <= vs_dly_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      rgb_q    <= rgb_d;
    end
  end

  assign x_coord = x_q;
  assign y_coord = y_q;
  assign idle    = idle_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign de      = de_q;
  assign red     = rgb_q[15:11];
  assign green   = rgb_q[10:5];
  assign blue    = rgb_q[4:0];

endmodule
